// File: rtl/apb_reg_bridge.sv
// APB completer that turns each transfer into one register-bus request and returns its response.
// Optional no-response abort is compiled in with `define APB_REG_BRIDGE_TIMEOUT_EN.
module apb_reg_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] REG_ADDR,
  output logic [DATA_WIDTH-1:0] REG_WDATA,
  output logic                  REG_VALID,
  output logic                  REG_READ,
  output logic                  REG_WRITE,
  input  logic [DATA_WIDTH-1:0] REG_RDATA,
  input  logic                  REG_ACK,
  input  logic                  REG_ERROR
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  read;
    logic                  write;
    logic                  valid;
  } req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  slverr;
  } rsp_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("apb_reg_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  state_t state, state_nxt;
  req_t   req_q, req_d;
  rsp_t   rsp_q, rsp_d;
  logic   setup, abort, finish;

  assign setup  = PSEL & ~PENABLE;
  assign finish = (state == REQ) & (REG_ACK | abort);

`ifdef APB_REG_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_nxt;

  // Counter equals (REQ cycles so far - 1), so abort lands on the TIMEOUT_CYCLES-th cycle.
  assign abort = (state == REQ) & ~REG_ACK & (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE && setup)        cnt_nxt = '0;
    else if (state == REQ && !REG_ACK) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt <= '0;
    else          cnt <= cnt_nxt;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (setup)  state_nxt = REQ;
      REQ:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next value of every registered output; PSEL is not looked at outside IDLE.
  always_comb begin
    req_d = req_q;
    rsp_d = rsp_q;
    unique case (state)
      IDLE: begin
        rsp_d = '0;
        if (setup) begin
          req_d.addr  = PADDR;
          req_d.wdata = PWDATA;
          req_d.write = PWRITE;
          req_d.read  = ~PWRITE;
          req_d.valid = 1'b1;
        end
      end
      REQ: if (finish) begin
        req_d.valid  = 1'b0;
        req_d.read   = 1'b0;
        req_d.write  = 1'b0;
        rsp_d.ready  = 1'b1;
        rsp_d.slverr = REG_ACK ? REG_ERROR : 1'b1;
        rsp_d.rdata  = (REG_ACK & ~REG_ERROR & req_q.read) ? REG_RDATA : '0;
      end
      DONE:    rsp_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      req_q <= req_d;
      rsp_q <= rsp_d;
    end
  end

  assign REG_ADDR  = req_q.addr;
  assign REG_WDATA = req_q.wdata;
  assign REG_VALID = req_q.valid;
  assign REG_READ  = req_q.read;
  assign REG_WRITE = req_q.write;
  assign PRDATA    = rsp_q.rdata;
  assign PREADY    = rsp_q.ready;
  assign PSLVERR   = rsp_q.slverr;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge: directed vector table, hand sequences, random transfers vs model.
module tb_apb_reg_bridge;
  localparam int T = 16;
`ifdef APB_REG_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK, PRESETn;
  logic [31:0] PADDR, PWDATA, PRDATA, REG_ADDR, REG_WDATA, REG_RDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic        REG_VALID, REG_READ, REG_WRITE, REG_ACK, REG_ERROR;

  int checks = 0;
  int errors = 0;

  apb_reg_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_VALID(REG_VALID), .REG_READ(REG_READ),
    .REG_WRITE(REG_WRITE), .REG_RDATA(REG_RDATA), .REG_ACK(REG_ACK), .REG_ERROR(REG_ERROR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr, wdata, rdata;
    bit          err;
    int          delay;
    logic [31:0] exp_prdata;
    bit          exp_err;
    int          exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: a slave that stays silent for T valid cycles gets aborted.
  task automatic model(input bit wr, input logic [31:0] rdata, input bit err, input int delay,
                       output logic [31:0] prd, output bit perr, output int cycles);
    bit timed_out;
    int vcyc;
    timed_out = TO_EN && (delay >= T);
    perr      = timed_out ? 1'b1 : err;
    prd       = (timed_out || err || wr) ? 32'h0 : rdata;
    vcyc      = timed_out ? T : delay + 1;
    cycles    = vcyc + 2;
  endtask

  // One APB transfer with a register slave that acks after `delay` wait cycles.
  task automatic xfer(input bit wr, input logic [31:0] addr, wdata, rdata, input bit err,
                      input int delay, output logic [31:0] prd, output bit perr,
                      output int cycles, output int vcyc);
    bit done, unstable;
    @(negedge PCLK);
    chk("pre_pready", 64'(PREADY), 64'(0));
    chk("pre_valid", 64'(REG_VALID), 64'(0));
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; REG_ACK = 1'b0;
    cycles = 1; vcyc = 0; done = 1'b0; unstable = 1'b0; prd = '0; perr = 1'b0;
    for (int g = 0; g < 300 && !done; g++) begin
      @(negedge PCLK);
      PENABLE = 1'b1;
      cycles++;
      REG_ACK = 1'b0; REG_RDATA = $urandom; REG_ERROR = 1'($urandom);
      if (PREADY) begin
        done = 1'b1; prd = PRDATA; perr = PSLVERR;
        chk("valid_drop", 64'({REG_VALID, REG_READ, REG_WRITE}), 64'(0));
      end else if (REG_VALID) begin
        vcyc++;
        if (vcyc == 1) begin
          chk("reg_addr", 64'(REG_ADDR), 64'(addr));
          chk("reg_rw", 64'({REG_READ, REG_WRITE}), 64'({!wr, wr}));
          if (wr) chk("reg_wdata", 64'(REG_WDATA), 64'(wdata));
        end else if (REG_ADDR !== addr || REG_READ !== !wr || REG_WRITE !== wr ||
                     (wr && REG_WDATA !== wdata)) begin
          unstable = 1'b1;
        end
        if (vcyc == delay + 1) begin
          REG_ACK = 1'b1; REG_RDATA = rdata; REG_ERROR = err;
        end
      end
    end
    REG_ACK = 1'b0;
    chk("completed", 64'(done), 64'(1));
    chk("req_stable", 64'(unstable), 64'(0));
  endtask

  task automatic idle(input int n, input bit bad);
    repeat (n) begin
      @(negedge PCLK);
      chk("idle_pready", 64'({PREADY, PSLVERR}), 64'(0));
      chk("idle_valid", 64'(REG_VALID), 64'(0));
      PSEL = bad; PENABLE = bad; REG_ACK = 1'($urandom); REG_ERROR = 1'b1; REG_RDATA = $urandom;
    end
    @(negedge PCLK);
    chk("idle_prdata", 64'(PRDATA), 64'(0));
    chk("idle_valid", 64'(REG_VALID), 64'(0));
    PSEL = 1'b0; PENABLE = 1'b0; REG_ACK = 1'b0; REG_ERROR = 1'b0;
  endtask

  vec_t        vt[9];
  logic [31:0] prd, eprd;
  bit          perr, eerr;
  int          cyc, vcyc, ecyc;

  initial begin
    vt[0] = '{1'b1, 32'h10, 32'hA5A5A5A5, 32'h0,        1'b0, 0,  32'h0,        1'b0, 3};
    vt[1] = '{1'b0, 32'h24, 32'h0,        32'hDEADBEEF, 1'b0, 3,  32'hDEADBEEF, 1'b0, 6};
    vt[2] = '{1'b0, 32'h30, 32'h0,        32'h12345678, 1'b1, 0,  32'h0,        1'b1, 3};
    vt[3] = '{1'b1, 32'h34, 32'h11,       32'h99,       1'b0, 1,  32'h0,        1'b0, 4};
    vt[4] = '{1'b1, 32'h0,  32'h1111,     32'h5555,     1'b0, 0,  32'h0,        1'b0, 3};
    vt[5] = '{1'b1, 32'h4,  32'h2222,     32'h0,        1'b0, 0,  32'h0,        1'b0, 3};
    vt[6] = '{1'b1, 32'h38, 32'h3333,     32'h77,       1'b1, 2,  32'h0,        1'b1, 5};
    vt[7] = '{1'b0, 32'h40, 32'h0,        32'h0BADF00D, 1'b0, 15, 32'h0BADF00D, 1'b0, 18};
`ifdef APB_REG_BRIDGE_TIMEOUT_EN
    vt[8] = '{1'b0, 32'h44, 32'h0,        32'h13572468, 1'b0, 100, 32'h0,       1'b1, 18};
`else
    vt[8] = '{1'b0, 32'h44, 32'h0,        32'h13572468, 1'b0, 100, 32'h13572468, 1'b0, 103};
`endif

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    REG_RDATA = '0; REG_ACK = 1'b0; REG_ERROR = 1'b0;
    #12;
    chk("rst_apb", 64'({PRDATA, PREADY, PSLVERR}), 64'(0));
    chk("rst_reg", 64'({REG_ADDR, REG_WDATA}), 64'(0));
    chk("rst_ctl", 64'({REG_VALID, REG_READ, REG_WRITE}), 64'(0));
    @(negedge PCLK); PRESETn = 1'b1;
    idle(2, 1'b0);

    // Directed table; entries 4/5 run back to back.
    foreach (vt[i]) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, vt[i].delay,
           prd, perr, cyc, vcyc);
      chk($sformatf("vec%0d_prdata", i), 64'(prd), 64'(vt[i].exp_prdata));
      chk($sformatf("vec%0d_pslverr", i), 64'(perr), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vt[i].exp_cycles));
      chk($sformatf("vec%0d_valid_cycles", i), 64'(vcyc), 64'(vt[i].exp_cycles - 2));
    end
    idle(3, 1'b1);
    chk("addr_hold", 64'(REG_ADDR), 64'(32'h44));

    // PSEL dropped mid-REQ: the request still finishes and PREADY still pulses.
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h60;
    @(negedge PCLK);
    PSEL = 1'b0;
    chk("drop_valid", 64'({REG_VALID, REG_READ}), 64'(3));
    @(negedge PCLK);
    REG_ACK = 1'b1; REG_RDATA = 32'hCAFEF00D; REG_ERROR = 1'b0;
    @(negedge PCLK);
    REG_ACK = 1'b0;
    chk("drop_pready", 64'({PREADY, PSLVERR}), 64'(2));
    chk("drop_prdata", 64'(PRDATA), 64'(32'hCAFEF00D));
    idle(1, 1'b0);

    // Reset mid-REQ clears outputs without waiting for a clock edge.
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h50; PWDATA = 32'h5050;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("mid_valid", 64'(REG_VALID), 64'(1));
    #2 PRESETn = 1'b0;
    #1 chk("async_rst", 64'({REG_VALID, PREADY, REG_WRITE}), 64'(0));
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    idle(1, 1'b0);
    xfer(1'b0, 32'h54, 32'h0, 32'h600DCAFE, 1'b0, 1, prd, perr, cyc, vcyc);
    chk("post_rst_prdata", 64'(prd), 64'(32'h600DCAFE));
    chk("post_rst_cycles", 64'({perr, 8'(cyc)}), 64'({1'b0, 8'd4}));

    // Random transfers against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      bit          wr, err;
      int          dly;
      logic [31:0] a, wd, rd;
      wr  = 1'($urandom); err = ($urandom_range(0, 3) == 0);
      a   = $urandom & 32'hFFFF_FFFC; wd = $urandom; rd = $urandom;
      dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 2, T + 2)) : int'($urandom_range(0, 4));
      model(wr, rd, err, dly, eprd, eerr, ecyc);
      xfer(wr, a, wd, rd, err, dly, prd, perr, cyc, vcyc);
      chk("rnd_prdata", 64'(prd), 64'(eprd));
      chk("rnd_pslverr", 64'(perr), 64'(eerr));
      chk("rnd_cycles", 64'(cyc), 64'(ecyc));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
